// File: rtl/float_div.sv
// -----------------------------------------------------------------------------
// float_div
//   Iterative floating-point divider: quot = dividend / divisor.
//   Packed format {sign, exponent, mantissa} with a hidden leading one.
//   A restoring divider retires one quotient bit per clock. Only one operation
//   is in flight at a time.
//
//   Flow: IDLE -> DIVIDE (Q edges) -> PACK -> DONE -> IDLE
//   Latency from the accept edge to outValid is MANTISSA_SIZE+3 edges
//   (MANTISSA_SIZE+4 with rounding). It does not depend on the operands.
//
//   Optional feature macro: FLOAT_DIV_ROUND_EN
//     undefined : mantissa truncated, Q = MANTISSA_SIZE+2 quotient bits
//     defined   : one extra quotient bit used as a round-half-up bit
//
// Ports
//   clk       rising-edge clock
//   resetn    asynchronous active-low reset (release expected synchronous)
//   inValid   operands valid
//   inReady   block idle; operands taken when inValid && inReady
//   dividend  numerator   (FLOAT_SIZE bits)
//   divisor   denominator (FLOAT_SIZE bits)
//   outValid  quot valid, held until outReady
//   outReady  consumer takes quot
//   quot      registered result (FLOAT_SIZE bits)
//
// Special operands (sign is always the XOR of the input signs):
//   exponent 0 is zero (subnormals flushed), divisor zero -> inf,
//   dividend inf/NaN-exponent -> inf, dividend zero -> zero,
//   divisor inf/NaN-exponent -> zero. NaN is never produced.
// -----------------------------------------------------------------------------
module float_div #(
   parameter  int MANTISSA_SIZE = 23,
   parameter  int EXPONENT_SIZE = 8,
   localparam int FLOAT_SIZE    = 1 + EXPONENT_SIZE + MANTISSA_SIZE
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  inValid,
   output logic                  inReady,
   input  logic [FLOAT_SIZE-1:0] dividend,
   input  logic [FLOAT_SIZE-1:0] divisor,
   output logic                  outValid,
   input  logic                  outReady,
   output logic [FLOAT_SIZE-1:0] quot
);

   localparam int M    = MANTISSA_SIZE;
   localparam int E    = EXPONENT_SIZE;
   localparam int XW   = E + 2;              // signed working exponent
   localparam int RW   = M + 2;              // partial remainder width
`ifdef FLOAT_DIV_ROUND_EN
   localparam int Q    = M + 3;              // includes one round bit
`else
   localparam int Q    = M + 2;
`endif
   localparam int CW   = $clog2(Q + 1);
   localparam int BIAS = 2**(E-1) - 1;
   localparam int EMAX = 2**E - 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DIVIDE,
      S_PACK,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic                  sign_q, sign_d;
   logic [XW-1:0]         exp_q, exp_d;
   logic [RW-1:0]         rem_q, rem_d;
   logic [M:0]            dvs_q, dvs_d;
   logic [Q-1:0]          quo_q, quo_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  inf_q, inf_d;
   logic                  zero_q, zero_d;
   logic [FLOAT_SIZE-1:0] quot_q, quot_d;

   // ---------------------------------------------------------------------------
   // Operand field decode (only meaningful on the accept edge)
   // ---------------------------------------------------------------------------
   logic         sa, sb;
   logic [E-1:0] ea, eb;
   logic [M-1:0] fa, fb;
   logic         a_zero, b_zero, a_max, b_max;

   assign sa     = dividend[FLOAT_SIZE-1];
   assign sb     = divisor[FLOAT_SIZE-1];
   assign ea     = dividend[M +: E];
   assign eb     = divisor[M +: E];
   assign fa     = dividend[M-1:0];
   assign fb     = divisor[M-1:0];
   assign a_zero = (ea == '0);
   assign b_zero = (eb == '0);
   assign a_max  = (ea == '1);
   assign b_max  = (eb == '1);

   // ---------------------------------------------------------------------------
   // One restoring-division step
   // ---------------------------------------------------------------------------
   logic [RW-1:0] dvs_ext;
   logic [RW-1:0] rem_sub;
   logic          q_bit;

   always_comb begin
      dvs_ext = {1'b0, dvs_q};
      q_bit   = (rem_q >= dvs_ext);
      rem_sub = q_bit ? (rem_q - dvs_ext) : rem_q;
   end

   // ---------------------------------------------------------------------------
   // Normalise / round / clamp of the finished quotient
   // ---------------------------------------------------------------------------
   logic [M-1:0]          mant_n;
   logic [XW-1:0]         exp_n;
   logic [FLOAT_SIZE-1:0] pack_res;
`ifdef FLOAT_DIV_ROUND_EN
   logic                  rnd_bit;
   logic [M:0]            mant_sum;
`endif

   always_comb begin
      mant_n   = '0;
      exp_n    = exp_q;
`ifdef FLOAT_DIV_ROUND_EN
      rnd_bit  = 1'b0;
      mant_sum = '0;
      // Quotient lies in (1/2, 2): top bit set means the result is in [1, 2).
      if (quo_q[Q-1]) begin
         mant_n  = quo_q[Q-2:2];
         rnd_bit = quo_q[1];
      end else begin
         mant_n  = quo_q[Q-3:1];
         rnd_bit = quo_q[0];
         exp_n   = exp_q - XW'(1);
      end
      // Round half up; a carry out of the mantissa leaves it all zeros and
      // bumps the exponent.
      mant_sum = {1'b0, mant_n} + {{M{1'b0}}, rnd_bit};
      mant_n   = mant_sum[M-1:0];
      if (mant_sum[M]) begin
         exp_n = exp_n + XW'(1);
      end
`else
      if (quo_q[Q-1]) begin
         mant_n = quo_q[Q-2:1];
      end else begin
         mant_n = quo_q[Q-3:0];
         exp_n  = exp_q - XW'(1);
      end
`endif
      pack_res = {sign_q, exp_n[E-1:0], mant_n};
      if (inf_q) begin
         pack_res = {sign_q, {E{1'b1}}, {M{1'b0}}};
      end else if (zero_q) begin
         pack_res = {sign_q, {(FLOAT_SIZE-1){1'b0}}};
      end else if ($signed(exp_n) >= $signed(XW'(EMAX))) begin
         pack_res = {sign_q, {E{1'b1}}, {M{1'b0}}};
      end else if ($signed(exp_n) <= $signed(XW'(0))) begin
         pack_res = {sign_q, {(FLOAT_SIZE-1){1'b0}}};
      end
   end

   // ---------------------------------------------------------------------------
   // FSM next state and datapath updates
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      sign_d  = sign_q;
      exp_d   = exp_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      quo_d   = quo_q;
      cnt_d   = cnt_q;
      inf_d   = inf_q;
      zero_d  = zero_q;
      quot_d  = quot_q;

      case (state_q)
         S_IDLE: begin
            if (inValid) begin
               sign_d  = sa ^ sb;
               exp_d   = XW'(ea) - XW'(eb) + XW'(BIAS);
               rem_d   = {1'b0, ~a_zero, fa};
               dvs_d   = {~b_zero, fb};
               quo_d   = '0;
               cnt_d   = CW'(Q);
               // Special-case class is fixed here; the divider still runs so
               // the latency stays constant.
               inf_d   = b_zero | a_max;
               zero_d  = ~(b_zero | a_max) & (a_zero | b_max);
               state_d = S_DIVIDE;
            end
         end
         S_DIVIDE: begin
            quo_d = {quo_q[Q-2:0], q_bit};
            rem_d = rem_sub << 1;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = S_PACK;
            end
         end
         S_PACK: begin
            quot_d  = pack_res;
            state_d = S_DONE;
         end
         S_DONE: begin
            if (outReady) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         sign_q  <= 1'b0;
         exp_q   <= '0;
         rem_q   <= '0;
         dvs_q   <= '0;
         quo_q   <= '0;
         cnt_q   <= '0;
         inf_q   <= 1'b0;
         zero_q  <= 1'b0;
         quot_q  <= '0;
      end else begin
         state_q <= state_d;
         sign_q  <= sign_d;
         exp_q   <= exp_d;
         rem_q   <= rem_d;
         dvs_q   <= dvs_d;
         quo_q   <= quo_d;
         cnt_q   <= cnt_d;
         inf_q   <= inf_d;
         zero_q  <= zero_d;
         quot_q  <= quot_d;
      end
   end

   assign inReady  = (state_q == S_IDLE);
   assign outValid = (state_q == S_DONE);
   assign quot     = quot_q;

endmodule

// File: tb/tb_float_div.sv
module tb_float_div;

`ifdef FLOAT_DIV_ROUND_EN
   localparam int LAT = 27;
`else
   localparam int LAT = 26;
`endif

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        inValid = 1'b0;
   logic        outReady = 1'b1;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
   logic        inReady;
   logic        outValid;
   logic [31:0] quot;

   float_div #(.MANTISSA_SIZE(23), .EXPONENT_SIZE(8)) dut (
      .clk      (clk),
      .resetn   (resetn),
      .inValid  (inValid),
      .inReady  (inReady),
      .dividend (dividend),
      .divisor  (divisor),
      .outValid (outValid),
      .outReady (outReady),
      .quot     (quot)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] exp_q [$];
   int          lat_q [$];
   logic        busy = 1'b0;
   logic        ready_viol = 1'b0;
   logic        prev_ov = 1'b0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      string       name;
   } vec_t;

   vec_t vt [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      nvec++;
      if (act !== req) begin
         nerr++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
      end else begin
         $display("ok   %s: %h (cycle %0d)", name, act, cyc);
      end
   endtask

   // Independent integer reference of the divider
   function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
      logic            s;
      int              ea, eb, e;
      longint unsigned ma, mb, q, m;
      s  = a[31] ^ b[31];
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      if (eb == 0)   return {s, 8'hFF, 23'h0};
      if (ea == 255) return {s, 8'hFF, 23'h0};
      if (ea == 0)   return {s, 31'h0};
      if (eb == 255) return {s, 31'h0};
      ma = {40'h0, 1'b1, a[22:0]};
      mb = {40'h0, 1'b1, b[22:0]};
      e  = ea - eb + 127;
`ifdef FLOAT_DIV_ROUND_EN
      q = (ma << 25) / mb;
      if (q >= (64'd1 << 25)) begin
         m = ((q >> 2) & 64'h7FFFFF) + ((q >> 1) & 64'd1);
      end else begin
         m = ((q >> 1) & 64'h7FFFFF) + (q & 64'd1);
         e = e - 1;
      end
      if (m == 64'h800000) begin
         m = 0;
         e = e + 1;
      end
`else
      q = (ma << 24) / mb;
      if (q >= (64'd1 << 24)) begin
         m = (q >> 1) & 64'h7FFFFF;
      end else begin
         m = q & 64'h7FFFFF;
         e = e - 1;
      end
`endif
      if (e >= 255) return {s, 8'hFF, 23'h0};
      if (e <= 0)   return {s, 31'h0};
      return {s, 8'(e), 23'(m)};
   endfunction

   // Monitor / scoreboard: sampled on the falling edge
   always @(negedge clk) begin
      if (!resetn) begin
         exp_q.delete();
         lat_q.delete();
         busy       = 1'b0;
         ready_viol = 1'b0;
         prev_ov    = 1'b0;
      end else begin
         if (busy && inReady) ready_viol = 1'b1;
         if (inValid && inReady) begin
            lat_q.push_back(cyc + 1 + LAT);
            busy       = 1'b1;
            ready_viol = 1'b0;
         end
         if (outValid && !prev_ov) begin
            if (lat_q.size() == 0) begin
               nvec++;
               nerr++;
               $display("FAIL unexpected outValid: quot %h, required no output", quot);
            end else begin
               check("latency", 32'(cyc), 32'(lat_q.pop_front()));
            end
         end
         if (outValid && outReady) begin
            if (exp_q.size() == 0) begin
               nvec++;
               nerr++;
               $display("FAIL unexpected result: quot %h, required none", quot);
            end else begin
               check("quot", quot, exp_q.pop_front());
               check("inReady low while busy", 32'(ready_viol), 32'(0));
            end
            busy = 1'b0;
         end
         prev_ov = outValid;
      end
   end

   task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q);
      int i;
      @(posedge clk);
      #1;
      dividend = a;
      divisor  = b;
      inValid  = 1'b1;
      exp_q.push_back(q);
      for (i = 0; i < 200; i++) begin
         @(negedge clk);
         if (inReady) break;
      end
      if (!inReady) begin
         nvec++;
         nerr++;
         $display("FAIL accept timeout: inReady 0, required 1");
      end
      @(posedge clk);
      #1;
      inValid  = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
   endtask

   task automatic wait_idle();
      int i;
      for (i = 0; i < 300; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      if (exp_q.size() != 0) begin
         nvec++;
         nerr++;
         $display("FAIL result timeout: %0d pending, required 0", exp_q.size());
         exp_q.delete();
         lat_q.delete();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ra, rb;
      int          ov_cnt;

      vt.push_back('{32'h40C00000, 32'h40000000, 32'h40400000, "6/2"});
`ifdef FLOAT_DIV_ROUND_EN
      vt.push_back('{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, "1/3"});
`else
      vt.push_back('{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, "1/3"});
`endif
      vt.push_back('{32'hBF800000, 32'h00000000, 32'hFF800000, "-1/0"});
      vt.push_back('{32'h7F000000, 32'h00800000, 32'h7F800000, "overflow"});
      vt.push_back('{32'h00800000, 32'h40000000, 32'h00000000, "underflow"});
      vt.push_back('{32'h40000000, 32'h40000000, 32'h3F800000, "2/2"});
      vt.push_back('{32'hC0C00000, 32'h40000000, 32'hC0400000, "-6/2"});
      vt.push_back('{32'h7F800000, 32'h3F800000, 32'h7F800000, "inf/1"});
      vt.push_back('{32'h3F800000, 32'h7F800000, 32'h00000000, "1/inf"});
      vt.push_back('{32'h00000000, 32'h00000000, 32'h7F800000, "0/0"});
      vt.push_back('{32'hFF800000, 32'h00000000, 32'hFF800000, "-inf/0"});
      vt.push_back('{32'h80000000, 32'h3F800000, 32'h80000000, "-0/1"});
      vt.push_back('{32'h00400000, 32'h3F800000, 32'h00000000, "subn/1"});
      vt.push_back('{32'h3F800000, 32'h80400000, 32'hFF800000, "1/-subn"});
      vt.push_back('{32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, "max/0.5"});
      vt.push_back('{32'h00800000, 32'h3F800001, 32'h00000000, "min/1+"});

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset quot", quot, 32'h0);
      check("reset outValid", 32'(outValid), 32'(0));
      check("reset inReady", 32'(inReady), 32'(1));
      resetn = 1'b1;

      // Directed table
      foreach (vt[i]) begin
         $display("vector %s: %h / %h", vt[i].name, vt[i].a, vt[i].b);
         apply(vt[i].a, vt[i].b, vt[i].q);
         wait_idle();
      end

      // Consumer stall: result held, new operands ignored until released
      outReady = 1'b0;
      apply(32'h40C00000, 32'h40000000, 32'h40400000);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (outValid) break;
      end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (i == 0) begin
            dividend = 32'h3F800000;
            divisor  = 32'h40400000;
            inValid  = 1'b1;
            exp_q.push_back(ref_div(32'h3F800000, 32'h40400000));
         end
         @(negedge clk);
         check("stall outValid", 32'(outValid), 32'(1));
         check("stall quot", quot, 32'h40400000);
         check("stall inReady", 32'(inReady), 32'(0));
      end
      @(posedge clk);
      #1;
      outReady = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("release outValid", 32'(outValid), 32'(0));
      check("release inReady", 32'(inReady), 32'(1));
      @(posedge clk);
      #1;
      inValid = 1'b0;
      wait_idle();

      // Reset mid-operation aborts the divide
      apply(32'h3F800000, 32'h40400000, 32'h3EAAAAAA);
      repeat (9) @(posedge clk);
      #1;
      resetn = 1'b0;
      #1;
      check("abort outValid", 32'(outValid), 32'(0));
      check("abort inReady", 32'(inReady), 32'(1));
      @(negedge clk);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      ov_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (outValid) ov_cnt++;
      end
      check("aborted result absent", 32'(ov_cnt), 32'(0));
      apply(32'h40C00000, 32'h40000000, 32'h40400000);
      wait_idle();

      // Back-to-back random normal operands against the reference model
      for (int n = 0; n < 300; n++) begin
         ra = $urandom;
         rb = $urandom;
         if (n % 4 == 0) begin
            ra[30:23] = 8'($urandom_range(1, 254));
            rb[30:23] = 8'($urandom_range(1, 254));
         end else begin
            ra[30:23] = 8'($urandom_range(90, 164));
            rb[30:23] = 8'($urandom_range(90, 164));
         end
         apply(ra, rb, ref_div(ra, rb));
      end
      wait_idle();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
